rank_filter_3x3: RTL
====================

RANK_FILTER_3X3 -- requirements
Module: rank_filter_3x3

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 430, pixels per line (>=3).
REQ-003 Parameter IMG_H, default 430, lines per frame (>=3).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mode  input  2  filter select: 00 median, 01 min, 10 max, 11 bypass.
REQ-007 in_valid  input  1  in_data holds a pixel.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  input pixel, raster order.
REQ-010 out_valid  output  1  out_data holds a result.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  result pixel, raster order.
REQ-013 out_sof  output  1  qualifies out_data as pixel (0,0).
REQ-014 out_eol  output  1  qualifies out_data as column IMG_W-1.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-017 Exactly IMG_W*IMG_H outputs per frame, raster order, one per input pixel.
REQ-018 Output (r,c): rank result of the 3x3 window centred on (r,c) when 1<=r<=IMG_H-2 and 1<=c<=IMG_W-2; otherwise the original pixel (border pass-through); bypass mode passes every pixel through.
REQ-019 Rank results: median = 5th smallest of 9, min = smallest, max = largest; unsigned DATA_W compare; no width growth.
REQ-020 Line storage: two IMG_W x DATA_W line buffers plus a 3x3 window register.
REQ-021 FSM states: IDLE, FILL, RUN, FLUSH.
REQ-022 IDLE -> FILL on first input transfer; mode is sampled at that transfer and held for the whole frame; mode changes mid-frame are ignored.
REQ-023 FILL: out_valid=0, in_ready=1; FILL -> RUN when accepted count reaches IMG_W+1.
REQ-024 RUN: each input transfer with linear index k produces output index k-(IMG_W+1) registered the following cycle.
REQ-025 RUN: in_ready = !out_valid || out_ready; no pixel is dropped or duplicated under any out_ready pattern.
REQ-026 RUN -> FLUSH when input index IMG_W*IMG_H-1 is accepted.
REQ-027 FLUSH: in_ready=0; the remaining IMG_W+1 outputs (all border pixels) are emitted from the line buffers, one per out_ready cycle.
REQ-028 FLUSH -> IDLE on transfer of the final output; the next frame may start the cycle after.
REQ-029 out_data, out_sof and out_eol hold stable while out_valid && !out_ready.
REQ-030 Latency: first output valid one cycle after the (IMG_W+2)th input transfer.

Reset
REQ-031 Reset forces state IDLE, all counters 0, out_valid=0, out_data=0, out_sof=0, out_eol=0, busy=0, window registers 0.
REQ-032 in_ready=1 in the first cycle after rst deasserts.
REQ-033 Line-buffer contents are not reset; the FILL sequence overwrites them before use.
REQ-034 Reset asserted mid-frame discards the partial frame; the next input starts a new frame.

Structure
REQ-035 Shared package holds the mode encodings (MODE_MEDIAN, MODE_MIN, MODE_MAX, MODE_BYPASS) and the FSM state encodings.
REQ-036 One combinational sub-module, sort9_rank, takes 9 pixels and returns min, median and max; the mode mux stays in rank_filter_3x3.
REQ-037 Counter widths derive from IMG_W and IMG_H via clog2; no fixed 10-bit counters.

Verification (IMG_W=4, IMG_H=4, DATA_W=8)
REQ-038 Ramp frame, pixel = 4r+c, median, out_ready=1 -> 16 outputs equal to the inputs; out_sof on output 0; out_eol on outputs 3, 7, 11, 15.
REQ-039 All pixels 10 except (1,1)=255 -> median: (1,1)=10. Max: (1,1), (1,2), (2,1), (2,2)=255 and (0,0)=10. Min: all interior pixels 10.
REQ-040 Ramp frame, out_ready toggling 1,0,1,0 -> same 16 values as REQ-038; in_ready=0 whenever out_valid && !out_ready.
REQ-041 After the 16th input is accepted -> in_ready=0 and busy=1 until 5 more outputs (values 11, 12, 13, 14, 15) transfer, then busy=0.
REQ-042 rst pulsed after 7 inputs -> out_valid=0 and in_ready=1 next cycle; the following full ramp frame matches REQ-038.
REQ-043 mode switched from median to max after input 6 -> the frame stays median; the next frame uses max.

Source files
------------

// File: rtl/rank_filter_3x3_pkg.sv
// Shared encodings for the 3x3 rank filter: filter modes, FSM states and
// the window geometry used by the sorter.
package rank_filter_3x3_pkg;

   typedef enum logic [1:0] {
      MODE_MEDIAN = 2'b00,
      MODE_MIN    = 2'b01,
      MODE_MAX    = 2'b10,
      MODE_BYPASS = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam int WIN_N       = 9;
   localparam int MEDIAN_RANK = 4;

endpackage

// File: rtl/rank_filter_3x3_sort9.sv
// Combinational rank selector: returns the smallest, 5th smallest and largest
// of nine unsigned pixels.
module sort9_rank
   import rank_filter_3x3_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic [WIN_N*DATA_W-1:0] pix,
   output logic [DATA_W-1:0]       min_pix,
   output logic [DATA_W-1:0]       med_pix,
   output logic [DATA_W-1:0]       max_pix
);

   logic [DATA_W-1:0] p    [WIN_N];
   logic [3:0]        rank [WIN_N];

   for (genvar gi = 0; gi < WIN_N; gi++) begin : g_unpack
      assign p[gi] = pix[gi*DATA_W +: DATA_W];
   end

   // Ties are broken by position, so every element gets a distinct rank 0..8.
   always_comb begin
      for (int i = 0; i < WIN_N; i++) begin
         rank[i] = '0;
         for (int j = 0; j < WIN_N; j++) begin
            if ((p[j] < p[i]) || ((p[j] == p[i]) && (j < i)))
               rank[i] = rank[i] + 4'd1;
         end
      end
   end

   always_comb begin
      min_pix = '0;
      med_pix = '0;
      max_pix = '0;
      for (int i = 0; i < WIN_N; i++) begin
         if (rank[i] == 4'd0)                min_pix = p[i];
         if (rank[i] == 4'(MEDIAN_RANK))     med_pix = p[i];
         if (rank[i] == 4'(WIN_N - 1))       max_pix = p[i];
      end
   end

endmodule

// File: rtl/rank_filter_3x3.sv
// Streaming 3x3 median/min/max filter with border pass-through, two line
// buffers and a single-entry output register with ready/valid handshake.
module rank_filter_3x3
   import rank_filter_3x3_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 430,
   parameter int IMG_H  = 430
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sof,
   output logic              out_eol,
   output logic              busy
);

   localparam int COL_W  = $clog2(IMG_W);
   localparam int IROW_W = $clog2(IMG_H + 2);
   localparam int OROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
   localparam logic [IROW_W-1:0] IROW_FILL = IROW_W'(1);
   localparam logic [IROW_W-1:0] IROW_LAST = IROW_W'(IMG_H - 1);
   localparam logic [OROW_W-1:0] OROW_LAST = OROW_W'(IMG_H - 1);

   state_t              state_reg, state_next;
   mode_t               mode_reg;
   logic [COL_W-1:0]    in_col_reg, in_col_next;
   logic [IROW_W-1:0]   in_row_reg, in_row_next;
   logic [COL_W-1:0]    out_col_reg;
   logic [OROW_W-1:0]   out_row_reg;
   logic [DATA_W-1:0]   lb0 [IMG_W];
   logic [DATA_W-1:0]   lb1 [IMG_W];
   logic [DATA_W-1:0]   lb0_rd_reg, lb1_rd_reg;
   logic [DATA_W-1:0]   win_reg [3][3];
   logic [DATA_W-1:0]   col_new [3];
   logic [9*DATA_W-1:0] win_flat;
   logic [DATA_W-1:0]   min_pix, med_pix, max_pix, rank_pix, center;
   logic                out_valid_reg, out_sof_reg, out_eol_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic                can_load, out_done, in_xfer, flush_step, advance, emit;
   logic                frame_end, border;

   assign can_load   = !out_valid_reg || out_ready;
   assign out_done   = (out_row_reg == '0) && (out_col_reg == '0);
   assign in_xfer    = in_valid && in_ready;
   // Flush pushes dummy pixels through the same path until the last output is loaded.
   assign flush_step = (state_reg == FLUSH) && can_load && !out_done;
   assign advance    = in_xfer || flush_step;
   assign emit       = advance && ((state_reg == RUN) || (state_reg == FLUSH));
   assign frame_end  = (state_reg == FLUSH) && out_done && out_valid_reg && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_xfer) state_next = FILL;
         FILL:    if (in_xfer && (in_row_reg == IROW_FILL) && (in_col_reg == '0))
                     state_next = RUN;
         RUN:     if (in_xfer && (in_row_reg == IROW_LAST) && (in_col_reg == COL_LAST))
                     state_next = FLUSH;
         FLUSH:   if (frame_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      case (state_reg)
         IDLE, FILL: in_ready = 1'b1;
         RUN:        in_ready = can_load;
         default:    in_ready = 1'b0;
      endcase
   end

   assign busy = (state_reg != IDLE);

   always_comb begin
      in_col_next = in_col_reg;
      in_row_next = in_row_reg;
      if (frame_end) begin
         in_col_next = '0;
         in_row_next = '0;
      end else if (advance) begin
         if (in_col_reg == COL_LAST) begin
            in_col_next = '0;
            in_row_next = in_row_reg + 1'b1;
         end else begin
            in_col_next = in_col_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_reg   <= MODE_MEDIAN;
         in_col_reg <= '0;
         in_row_reg <= '0;
      end else begin
         in_col_reg <= in_col_next;
         in_row_reg <= in_row_next;
         if ((state_reg == IDLE) && in_xfer) mode_reg <= mode_t'(mode);
      end
   end

   // Reads are prefetched at the column the next advance will use.
   always_ff @(posedge clk) begin
      if (advance) begin
         lb0[in_col_reg] <= lb1_rd_reg;
         lb1[in_col_reg] <= in_data;
      end
      lb0_rd_reg <= lb0[in_col_next];
      lb1_rd_reg <= lb1[in_col_next];
   end

   assign col_new[0] = lb0_rd_reg;
   assign col_new[1] = lb1_rd_reg;
   assign col_new[2] = in_data;

   for (genvar gi = 0; gi < 3; gi++) begin : g_win
      assign win_flat[(gi*3+0)*DATA_W +: DATA_W] = win_reg[gi][1];
      assign win_flat[(gi*3+1)*DATA_W +: DATA_W] = win_reg[gi][2];
      assign win_flat[(gi*3+2)*DATA_W +: DATA_W] = col_new[gi];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_reg[r][c] <= '0;
      end else if (advance) begin
         for (int r = 0; r < 3; r++) begin
            win_reg[r][0] <= win_reg[r][1];
            win_reg[r][1] <= win_reg[r][2];
            win_reg[r][2] <= col_new[r];
         end
      end
   end

   sort9_rank #(.DATA_W(DATA_W)) u_sort (
      .pix     (win_flat),
      .min_pix (min_pix),
      .med_pix (med_pix),
      .max_pix (max_pix)
   );

   assign center = win_reg[1][2];
   assign border = (mode_reg == MODE_BYPASS) || (out_row_reg == '0) ||
                   (out_row_reg == OROW_LAST) || (out_col_reg == '0) ||
                   (out_col_reg == COL_LAST);

   always_comb begin
      rank_pix = center;
      case (mode_reg)
         MODE_MEDIAN: rank_pix = med_pix;
         MODE_MIN:    rank_pix = min_pix;
         MODE_MAX:    rank_pix = max_pix;
         default:     rank_pix = center;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sof_reg   <= 1'b0;
         out_eol_reg   <= 1'b0;
         out_col_reg   <= '0;
         out_row_reg   <= '0;
      end else if (emit) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= border ? center : rank_pix;
         out_sof_reg   <= (out_row_reg == '0) && (out_col_reg == '0);
         out_eol_reg   <= (out_col_reg == COL_LAST);
         if (out_col_reg == COL_LAST) begin
            out_col_reg <= '0;
            out_row_reg <= (out_row_reg == OROW_LAST) ? '0 : out_row_reg + 1'b1;
         end else begin
            out_col_reg <= out_col_reg + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sof   = out_sof_reg;
   assign out_eol   = out_eol_reg;

endmodule
